// File: rtl/alu_share_arbiter_if.sv
// Requester-side handshake bundle for alu_share_arbiter: two request ports and two response
// ports sharing one registered result/error bus.
interface alu_share_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 4
) ();
  logic              req_valid_0;
  logic              req_valid_1;
  logic              req_ready_0;
  logic              req_ready_1;
  logic [DATA_W-1:0] req_a_0;
  logic [DATA_W-1:0] req_a_1;
  logic [DATA_W-1:0] req_b_0;
  logic [DATA_W-1:0] req_b_1;
  logic [CTRL_W-1:0] req_ctrl_0;
  logic [CTRL_W-1:0] req_ctrl_1;
  logic              resp_valid_0;
  logic              resp_valid_1;
  logic              resp_ready_0;
  logic              resp_ready_1;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;

  // Requester side.
  modport master (
    output req_valid_0, req_valid_1, req_a_0, req_a_1, req_b_0, req_b_1,
    output req_ctrl_0, req_ctrl_1, resp_ready_0, resp_ready_1,
    input  req_ready_0, req_ready_1, resp_valid_0, resp_valid_1, resp_data, resp_err
  );

  // Arbiter side.
  modport slave (
    input  req_valid_0, req_valid_1, req_a_0, req_a_1, req_b_0, req_b_1,
    input  req_ctrl_0, req_ctrl_1, resp_ready_0, resp_ready_1,
    output req_ready_0, req_ready_1, resp_valid_0, resp_valid_1, resp_data, resp_err
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two valid/ready requesters.
// Optional ALU_ILLEGAL_OP_CHECK_EN: unknown op codes return 0 with resp_err set.
module alu_share_arbiter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CTRL_W     = 4,
  parameter int unsigned MASK_SHAMT = 1
) (
  input  logic              clk,
  input  logic              reset,
  alu_share_arbiter_if.slave bus,
  output logic [DATA_W-1:0] alu_inp1,
  output logic [DATA_W-1:0] alu_inp2,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [DATA_W-1:0] alu_out1
);

  localparam int unsigned ShW = $clog2(DATA_W);

  localparam logic [CTRL_W-1:0] OpAdd = CTRL_W'(4'b1000);
  localparam logic [CTRL_W-1:0] OpSub = CTRL_W'(4'b1010);
  localparam logic [CTRL_W-1:0] OpAnd = CTRL_W'(4'b1100);
  localparam logic [CTRL_W-1:0] OpOr  = CTRL_W'(4'b1101);
  localparam logic [CTRL_W-1:0] OpSll = CTRL_W'(4'b0000);
  localparam logic [CTRL_W-1:0] OpSrl = CTRL_W'(4'b0010);

  typedef enum logic [0:0] {StIdle, StResp} state_e;

  state_e            state_q, state_d;
  logic              prio_q;
  logic              owner_q;
  logic [DATA_W-1:0] resp_data_q;
  logic              resp_err_q;

  logic              grant;
  logic              winner;
  logic [DATA_W-1:0] win_a;
  logic [DATA_W-1:0] win_b;
  logic [DATA_W-1:0] win_b_fwd;
  logic [CTRL_W-1:0] win_ctrl;
  logic              win_legal;
  logic              is_shift;
  logic              owner_ready;
  logic              ready_0, ready_1, rvalid_0, rvalid_1;

  // Arbitration: only evaluated in IDLE; ties go to prio_q.
  always_comb begin
    grant  = 1'b0;
    winner = prio_q;
    if (state_q == StIdle) begin
      if (bus.req_valid_0 && bus.req_valid_1) begin
        grant  = 1'b1;
        winner = prio_q;
      end else if (bus.req_valid_0) begin
        grant  = 1'b1;
        winner = 1'b0;
      end else if (bus.req_valid_1) begin
        grant  = 1'b1;
        winner = 1'b1;
      end
    end
  end

  assign win_a    = winner ? bus.req_a_1    : bus.req_a_0;
  assign win_b    = winner ? bus.req_b_1    : bus.req_b_0;
  assign win_ctrl = winner ? bus.req_ctrl_1 : bus.req_ctrl_0;
  assign is_shift = (win_ctrl == OpSll) || (win_ctrl == OpSrl);

  always_comb begin
    win_b_fwd = win_b;
    if ((MASK_SHAMT != 0) && is_shift) begin
      win_b_fwd = {{(DATA_W-ShW){1'b0}}, win_b[ShW-1:0]};
    end
  end

`ifdef ALU_ILLEGAL_OP_CHECK_EN
  assign win_legal = (win_ctrl == OpAdd) || (win_ctrl == OpSub) || (win_ctrl == OpAnd) ||
                     (win_ctrl == OpOr)  || is_shift;
`else
  assign win_legal = 1'b1;
`endif

  assign owner_ready = owner_q ? bus.resp_ready_1 : bus.resp_ready_0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (grant)       state_d = StResp;
      StResp: if (owner_ready) state_d = StIdle;
    endcase
  end

  // Handshake outputs are forced low while reset is held.
  always_comb begin
    ready_0  = 1'b0;
    ready_1  = 1'b0;
    rvalid_0 = 1'b0;
    rvalid_1 = 1'b0;
    alu_inp1 = '0;
    alu_inp2 = '0;
    alu_ctrl = OpAdd;
    unique case (state_q)
      StIdle: begin
        if (grant && !reset) begin
          ready_0 = ~winner;
          ready_1 = winner;
        end
        if (grant && win_legal) begin
          alu_inp1 = win_a;
          alu_inp2 = win_b_fwd;
          alu_ctrl = win_ctrl;
        end
      end
      StResp: begin
        if (!reset) begin
          rvalid_0 = ~owner_q;
          rvalid_1 = owner_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q      <= 1'b0;
      owner_q     <= 1'b0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      if (state_q == StIdle && grant) begin
        owner_q     <= winner;
        resp_data_q <= win_legal ? alu_out1 : '0;
        resp_err_q  <= ~win_legal;
      end
      if (state_q == StResp && owner_ready) begin
        prio_q <= ~owner_q;
      end
    end
  end

  assign bus.req_ready_0  = ready_0;
  assign bus.req_ready_1  = ready_1;
  assign bus.resp_valid_0 = rvalid_0;
  assign bus.resp_valid_1 = rvalid_1;
  assign bus.resp_data    = resp_data_q;
  assign bus.resp_err     = resp_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: a driver issues directed ops and queues hand-computed
// results on acceptance; a monitor compares every presented response against the queue head.
module tb_alu_share_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;
  localparam int unsigned MS = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] alu_inp1, alu_inp2, alu_out1;
  logic [CW-1:0] alu_ctrl;

  alu_share_arbiter_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();

  alu_share_arbiter #(.DATA_W(DW), .CTRL_W(CW), .MASK_SHAMT(MS)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .alu_inp1 (alu_inp1),
    .alu_inp2 (alu_inp2),
    .alu_ctrl (alu_ctrl),
    .alu_out1 (alu_out1)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared ALU; unknown codes return a marker value.
  always_comb begin
    alu_out1 = 32'hDEADBEEF;
    case (alu_ctrl)
      4'b1000: alu_out1 = alu_inp1 + alu_inp2;
      4'b1010: alu_out1 = alu_inp1 - alu_inp2;
      4'b1100: alu_out1 = alu_inp1 & alu_inp2;
      4'b1101: alu_out1 = alu_inp1 | alu_inp2;
      4'b0000: alu_out1 = alu_inp1 << alu_inp2;
      4'b0010: alu_out1 = alu_inp1 >> alu_inp2;
      default: alu_out1 = 32'hDEADBEEF;
    endcase
  end

  typedef struct {
    bit            port;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  exp_t          sb[$];
  int            acc_port[$];
  int            acc_cyc[$];
  int            resp_cnt[2] = '{0, 0};
  logic [DW-1:0] exp_data[2];
  logic          exp_err[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: logs acceptances (pushing the driver's expected result) and checks responses.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      if (bus.req_ready_0 || bus.req_ready_1)
        check("ready_onehot", bus.req_ready_0 & bus.req_ready_1, 0);
      if (bus.req_ready_0) begin
        check("ready0_has_valid", bus.req_valid_0, 1);
        sb.push_back('{1'b0, exp_data[0], exp_err[0]});
        acc_port.push_back(0);
        acc_cyc.push_back(cyc);
      end
      if (bus.req_ready_1) begin
        check("ready1_has_valid", bus.req_valid_1, 1);
        sb.push_back('{1'b1, exp_data[1], exp_err[1]});
        acc_port.push_back(1);
        acc_cyc.push_back(cyc);
      end
      if (bus.resp_valid_0 || bus.resp_valid_1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_resp: resp_valid_1/0=%b%b with nothing pending, required 00",
                   bus.resp_valid_1, bus.resp_valid_0);
        end else begin
          check("resp_valid_onehot", bus.resp_valid_0 & bus.resp_valid_1, 0);
          check("resp_port", bus.resp_valid_1, sb[0].port);
          check("resp_data", bus.resp_data, sb[0].data);
          check("resp_err", bus.resp_err, sb[0].err);
          if ((bus.resp_valid_0 && bus.resp_ready_0) || (bus.resp_valid_1 && bus.resp_ready_1)) begin
            resp_cnt[bus.resp_valid_1 ? 1 : 0]++;
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  task automatic set_req(input int p, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [CW-1:0] c, input logic [DW-1:0] d, input logic e);
    exp_data[p] = d;
    exp_err[p]  = e;
    if (p == 0) begin
      bus.req_a_0 = a; bus.req_b_0 = b; bus.req_ctrl_0 = c; bus.req_valid_0 = 1'b1;
    end else begin
      bus.req_a_1 = a; bus.req_b_1 = b; bus.req_ctrl_1 = c; bus.req_valid_1 = 1'b1;
    end
  endtask

  task automatic drop(input int p);
    if (p == 0) bus.req_valid_0 = 1'b0;
    else        bus.req_valid_1 = 1'b0;
  endtask

  // Leaves the caller at the negedge where port p's req_ready is seen high.
  task automatic wait_ready(input int p);
    bit ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = (p == 0) ? bus.req_ready_0 : bus.req_ready_1;
    end
    check($sformatf("grant_timeout_p%0d", p), ok, 1);
  endtask

  task automatic wait_resp(input int p, input int n0);
    bit ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk);
      ok = (resp_cnt[p] > n0);
    end
    check($sformatf("resp_timeout_p%0d", p), ok, 1);
    #1;
  endtask

  task automatic wait_acc(input int target);
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge clk);
      ok = (acc_port.size() >= target);
    end
    check("acc_timeout", ok, 1);
    #1;
  endtask

  task automatic do_op(input int p, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [CW-1:0] c, input logic [DW-1:0] d, input logic e);
    int n0 = resp_cnt[p];
    if (p == 0) bus.resp_ready_0 = 1'b1;
    else        bus.resp_ready_1 = 1'b1;
    set_req(p, a, b, c, d, e);
    wait_ready(p);
    @(posedge clk); #1;
    drop(p);
    wait_resp(p, n0);
  endtask

  initial begin
    int base, n0, n1;
    bus.req_valid_0 = 1'b1; bus.req_valid_1 = 1'b1;
    bus.req_a_0 = '0; bus.req_b_0 = '0; bus.req_ctrl_0 = 4'b1000;
    bus.req_a_1 = '0; bus.req_b_1 = '0; bus.req_ctrl_1 = 4'b1000;
    bus.resp_ready_0 = 1'b0; bus.resp_ready_1 = 1'b0;
    exp_data[0] = '0; exp_data[1] = '0; exp_err[0] = 1'b0; exp_err[1] = 1'b0;

    // Readies must stay low under reset even with requests present.
    repeat (2) @(negedge clk);
    check("rst_ready0", bus.req_ready_0, 0);
    check("rst_ready1", bus.req_ready_1, 0);
    check("rst_rvalid0", bus.resp_valid_0, 0);
    check("rst_rvalid1", bus.resp_valid_1, 0);
    @(posedge clk); #1;
    drop(0); drop(1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_resp_data", bus.resp_data, 0);
    check("rst_resp_err", bus.resp_err, 0);
    check("idle_inp1", alu_inp1, 0);
    check("idle_inp2", alu_inp2, 0);
    check("idle_ctrl", alu_ctrl, 4'b1000);
    @(posedge clk); #1;

    // Single add with backpressure on the response.
    set_req(0, 5, 3, 4'b1000, 8, 0);
    @(negedge clk);
    check("add_ready0", bus.req_ready_0, 1);
    check("add_inp1", alu_inp1, 5);
    check("add_inp2", alu_inp2, 3);
    check("add_ctrl", alu_ctrl, 4'b1000);
    @(posedge clk); #1;
    drop(0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_rvalid0", bus.resp_valid_0, 1);
      check("hold_ready0", bus.req_ready_0, 0);
    end
    @(posedge clk); #1;
    bus.resp_ready_0 = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready_0 = 1'b0;
    check("add_resp_cnt", resp_cnt[0], 1);

    // Shift amount masking: 1 << 0x21.
    do_op(1, 1, 32'h21, 4'b0000, (MS != 0) ? 32'd2 : 32'd0, 0);

    // Saturated tie: grants must alternate starting at port 0, two cycles apart.
    base = acc_port.size(); n0 = resp_cnt[0]; n1 = resp_cnt[1];
    bus.resp_ready_0 = 1'b1; bus.resp_ready_1 = 1'b1;
    set_req(0, 10, 4, 4'b1010, 6, 0);
    set_req(1, 32'hF0, 32'h3C, 4'b1100, 32'h30, 0);
    wait_acc(base + 4);
    drop(0); drop(1);
    for (int i = 0; i < 4; i++) begin
      if (acc_port.size() > base + i) begin
        check($sformatf("rr_order_%0d", i), acc_port[base+i], i % 2);
        if (i > 0) check($sformatf("rr_gap_%0d", i), acc_cyc[base+i] - acc_cyc[base+i-1], 2);
      end
    end
    repeat (4) @(posedge clk); #1;
    check("rr_cnt0", resp_cnt[0] - n0, 2);
    check("rr_cnt1", resp_cnt[1] - n1, 2);

    // Serve port 0 so prio points at port 1, then reset mid-response on port 1.
    do_op(0, 32'h0F, 32'hF0, 4'b1101, 32'hFF, 0);
    bus.resp_ready_1 = 1'b0;
    set_req(1, 32'h80000000, 31, 4'b0010, 1, 0);
    wait_ready(1);
    @(posedge clk); #1;
    drop(1);
    @(negedge clk);
    check("srl_rvalid1", bus.resp_valid_1, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_rvalid1_in", bus.resp_valid_1, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_rvalid1_after", bus.resp_valid_1, 0);
    check("midrst_rvalid0_after", bus.resp_valid_0, 0);
    check("midrst_data", bus.resp_data, 0);
    @(posedge clk); #1;
    base = acc_port.size();
    bus.resp_ready_0 = 1'b1; bus.resp_ready_1 = 1'b1;
    set_req(0, 2, 3, 4'b1000, 5, 0);
    set_req(1, 32'h0F, 32'h30, 4'b1101, 32'h3F, 0);
    wait_acc(base + 1);
    if (acc_port.size() > base) check("tie_after_reset", acc_port[base], 0);
    drop(0);
    wait_acc(base + 2);
    drop(1);
    repeat (3) @(posedge clk); #1;

    // Port 0 loses a tie and withdraws; only port 1 may answer.
    do_op(0, 1, 1, 4'b1000, 2, 0);
    n0 = resp_cnt[0]; n1 = resp_cnt[1];
    set_req(0, 3, 3, 4'b1000, 6, 0);
    set_req(1, 7, 2, 4'b1010, 5, 0);
    wait_ready(1);
    check("drop_loser_ready0", bus.req_ready_0, 0);
    @(posedge clk); #1;
    drop(0); drop(1);
    repeat (6) @(posedge clk); #1;
    check("drop_cnt0", resp_cnt[0] - n0, 0);
    check("drop_cnt1", resp_cnt[1] - n1, 1);

    // Unknown op code 1111.
    n0 = resp_cnt[0];
`ifdef ALU_ILLEGAL_OP_CHECK_EN
    set_req(0, 7, 7, 4'b1111, 0, 1);
`else
    set_req(0, 7, 7, 4'b1111, 32'hDEADBEEF, 0);
`endif
    wait_ready(0);
`ifdef ALU_ILLEGAL_OP_CHECK_EN
    check("illegal_ctrl", alu_ctrl, 4'b1000);
    check("illegal_inp1", alu_inp1, 0);
`else
    check("illegal_ctrl", alu_ctrl, 4'b1111);
    check("illegal_inp1", alu_inp1, 7);
`endif
    @(posedge clk); #1;
    drop(0);
    wait_resp(0, n0);
    do_op(0, 32'h0F, 32'hF0, 4'b1101, 32'hFF, 0);

    repeat (3) @(posedge clk);
    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares the single combinational ALU between two requesters, e.g. the core's execute stage (port 0) and a debug/CSR helper (port 1), with round-robin arbitration. It uses valid/ready on both request and response sides and registers each result. It drives the ALU's operand and control inputs and samples its result. It sits between the requesters and the ALU instance in the datapath.

Parameters:
DATA_W, 32, operand/result width; must be a power of two, at least 8.
CTRL_W, 4, ALU control code width.
MASK_SHAMT, 1, when 1, shift ops (ctrl 0000, 0010) forward only operand-b bits [log2(DATA_W)-1:0], upper bits zeroed; when 0, operand b is forwarded unchanged.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high reset.
req_valid_0 / req_valid_1  in  1  request present on port 0 / port 1.
req_ready_0 / req_ready_1  out  1  request accepted this cycle.
req_a_0 / req_a_1  in  DATA_W  operand a.
req_b_0 / req_b_1  in  DATA_W  operand b.
req_ctrl_0 / req_ctrl_1  in  CTRL_W  ALU op code (1000 add, 1010 sub, 1100 and, 1101 or, 0000 sll, 0010 srl).
resp_valid_0 / resp_valid_1  out  1  result available for port 0 / port 1.
resp_ready_0 / resp_ready_1  in  1  requester takes result.
resp_data  out  DATA_W  registered result, shared by both ports.
resp_err  out  1  illegal op flag; see Optional Feature.
alu_inp1  out  DATA_W  to ALU inp1.
alu_inp2  out  DATA_W  to ALU inp2.
alu_ctrl  out  CTRL_W  to ALU ctrl.
alu_out1  in  DATA_W  from ALU out1.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: state=IDLE, prio=0, resp_data=0, resp_err=0. All resp_valid and req_ready outputs are 0 while reset is high.
- FSM states: IDLE, RESP.
- IDLE, no request: req_ready_* = 0; ALU driven with alu_inp1=0, alu_inp2=0, alu_ctrl=1000.
- IDLE, one request valid: grant that port.
- IDLE, both valid: grant the port equal to prio.
- Grant in IDLE (same cycle, combinational):
  - req_ready of the winner = 1; the loser's req_ready = 0.
  - ALU driven from the winner's a, b (masked per MASK_SHAMT) and ctrl.
  - At the clock edge: resp_data <= alu_out1, owner <= winner, state -> RESP.
- RESP:
  - resp_valid_<owner> = 1; the other resp_valid = 0.
  - req_ready_0 = req_ready_1 = 0; ALU driven with idle values.
  - resp_data and resp_err held stable.
  - When resp_ready_<owner> = 1: state -> IDLE, prio <= ~owner.
  - resp_ready of the non-owner is ignored.
- Latency: request accepted at edge N; resp_valid high from cycle N+1. Best-case throughput is one op per 2 cycles.
- Fairness: after serving port p, the other port wins the next tie. There is no starvation with both ports saturated, and grants alternate 0,1,0,1.
- Request signals are only sampled in the grant cycle. A requester may change or drop a request while not granted.
- Reset mid-operation: any pending result is discarded, state -> IDLE, prio -> 0, and no resp_valid is asserted in the cycle after reset.
- Arithmetic: performed entirely by the ALU; wrap-around mod 2^DATA_W is passed through unchanged.

Optional Feature:
ALU_ILLEGAL_OP_CHECK_EN.
- Defined: a grant with ctrl outside {1000, 1010, 1100, 1101, 0000, 0010} still completes the handshake. For such a grant:
  - ALU driven with idle values.
  - At the edge: resp_data <= 0, resp_err <= 1.
  - resp_err is valid with resp_valid; legal ops capture resp_err <= 0.
- Undefined: ctrl is forwarded unchanged and resp_data <= alu_out1 whatever the ALU produces; resp_err is tied 0.

Test Plan:
- Reset, then port 0 requests a=5, b=3, ctrl=1000 -> req_ready_0=1 in the same cycle; next cycle resp_valid_0=1, resp_data=8; hold resp_ready_0=0 for 3 cycles -> data stays 8.
- Both ports valid continuously: p0 1010 (10,4), p1 1100 (0xF0,0x3C), resp_ready tied 1 -> grant order 0,1,0,1; results 6, 0x30 alternating; each result 2 cycles apart.
- MASK_SHAMT=1, port 1 sll with a=1, b=0x21 -> resp_data=2. With MASK_SHAMT=0 -> resp_data=0.
- Port 1 issues srl a=0x80000000, b=31; reset asserted in the RESP cycle -> resp_valid_1=0 after reset; prio=0, so a following tie grants port 0.
- With ALU_ILLEGAL_OP_CHECK_EN: ctrl=1111, a=7, b=7 -> resp_data=0, resp_err=1. The next legal or 1101 (0x0F,0xF0) -> 0xFF, resp_err=0.
- Port 0 request is dropped in the cycle port 1 is granted -> no response for port 0, and port 1's result is returned correctly.
